conveng_sched: RTL

Sequencer for the 2D shift register file convolution engine. Pulls image rows from an upstream row stream and issues row-load and column-rotate commands to the engine. Presents each resulting window to a downstream consumer under a valid/ready handshake. Sits between the line fetcher and the conveng datapath and owns every rowShift/colShift strobe.

---
 rtl/conveng_sched_if.sv | 32 +++
 rtl/conveng_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/conveng_sched_if.sv
// Row-stream, engine-strobe and window handshake bundle for the conveng scheduler.
// Latency: none, plain wiring.
// Backpressure: in_valid/in_ready upstream, win_valid/win_ready downstream.
interface conveng_sched_if #(
    parameter int NUM_COL    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ROW_CNT_W  = 10,
    parameter int COL_CNT_W  = 3
);
    logic [NUM_COL*DATA_WIDTH-1:0] in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_COL*DATA_WIDTH-1:0] rf_data;
    logic                          rf_row_shift;
    logic                          rf_col_shift;
    logic                          win_valid;
    logic                          win_ready;
    logic [ROW_CNT_W-1:0]          win_row;
    logic [COL_CNT_W-1:0]          win_col;

    // Scheduler side
    modport master (
        input  in_data, in_valid, win_ready,
        output in_ready, rf_data, rf_row_shift, rf_col_shift, win_valid, win_row, win_col
    );

    // Line fetcher / engine / consumer side
    modport slave (
        output in_data, in_valid, win_ready,
        input  in_ready, rf_data, rf_row_shift, rf_col_shift, win_valid, win_row, win_col
    );
endinterface

// File: rtl/conveng_sched.sv
// Sequencer for the 2D shift-RF conv engine: fills NUM_ROW rows, rotates each row set through NUM_COL windows, reloads one row per sweep.
// Latency: start->in_ready 1 cycle, last fill accept->win_valid 1 cycle, final window accept->done 1 cycle.
// Backpressure: win_ready low freezes the window with no shift; in_valid low stalls fill/load. CONVENG_SCHED_PERF_EN adds stall_cnt.
module conveng_sched #(
    parameter int NUM_ROW    = 3,
    parameter int NUM_COL    = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ROW_CNT_W  = 10,
    parameter int COL_CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROW_CNT_W-1:0] img_rows,
    conveng_sched_if.master      eng,
    output logic                 busy,
    output logic                 done
`ifdef CONVENG_SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);
    localparam int FILL_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam logic [ROW_CNT_W-1:0] ROWS_N    = ROW_CNT_W'(NUM_ROW);
    localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(NUM_ROW - 1);
    localparam logic [COL_CNT_W-1:0] COL_LAST  = COL_CNT_W'(NUM_COL - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SWEEP = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [FILL_W-1:0]    fill_cnt, fill_nxt;
    logic [ROW_CNT_W-1:0] rows_loaded, rows_nxt;
    logic [ROW_CNT_W-1:0] rows_lat, lat_nxt;
    logic [COL_CNT_W-1:0] col, col_nxt;

    logic in_rdy, win_vld, row_shift, col_shift, done_p;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            rows_loaded <= '0;
            rows_lat    <= '0;
            col         <= '0;
        end else begin
            state       <= state_nxt;
            fill_cnt    <= fill_nxt;
            rows_loaded <= rows_nxt;
            rows_lat    <= lat_nxt;
            col         <= col_nxt;
        end
    end

    // Next-state and strobe decode; shifts fire in the same cycle as the handshake they belong to
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        rows_nxt  = rows_loaded;
        lat_nxt   = rows_lat;
        col_nxt   = col;
        in_rdy    = 1'b0;
        win_vld   = 1'b0;
        row_shift = 1'b0;
        col_shift = 1'b0;
        done_p    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    lat_nxt = img_rows;
                    if (img_rows < ROWS_N) begin
                        // Too short for even one window: finish without touching the engine
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FILL;
                        fill_nxt  = '0;
                    end
                end
            end
            FILL: begin
                in_rdy = 1'b1;
                if (eng.in_valid) begin
                    row_shift = 1'b1;
                    if (fill_cnt == FILL_LAST) begin
                        state_nxt = SWEEP;
                        fill_nxt  = '0;
                        col_nxt   = '0;
                        rows_nxt  = ROWS_N;
                    end else begin
                        fill_nxt = fill_cnt + 1'b1;
                    end
                end
            end
            SWEEP: begin
                win_vld = 1'b1;
                if (eng.win_ready) begin
                    col_shift = 1'b1;
                    if (col == COL_LAST) begin
                        // Full rotation: RF is back in its original column alignment
                        col_nxt   = '0;
                        state_nxt = (rows_loaded == rows_lat) ? DONE : LOAD;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            LOAD: begin
                in_rdy = 1'b1;
                if (eng.in_valid) begin
                    row_shift = 1'b1;
                    rows_nxt  = rows_loaded + 1'b1;
                    state_nxt = SWEEP;
                end
            end
            DONE: begin
                done_p    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign eng.in_ready     = in_rdy;
    assign eng.rf_data      = eng.in_data;
    assign eng.rf_row_shift = row_shift;
    assign eng.rf_col_shift = col_shift;
    assign eng.win_valid    = win_vld;
    // Top row of the window; forced to 0 outside a sweep so it never shows a wrapped value
    assign eng.win_row      = (state == SWEEP) ? (rows_loaded - ROWS_N) : '0;
    assign eng.win_col      = col;
    assign busy             = (state != IDLE);
    assign done             = done_p;

`ifdef CONVENG_SCHED_PERF_EN
    logic stall_ev;
    assign stall_ev = ((state == SWEEP) && !eng.win_ready) ||
                      (((state == FILL) || (state == LOAD)) && !eng.in_valid);

    // Saturating stall counter, cleared when a frame is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (stall_ev && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule
